// File: rtl/axil_reg_slave_if.sv
// ============================================================================
//  Module   : axil_reg_slave_if
//  Brief    : AXI4-Lite port group (AW/W/B/AR/R) with master and slave views.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [c_BYTES-1:0]    wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axil_reg_slave.sv
// ============================================================================
//  Module   : axil_reg_slave
//  Brief    : AXI4-Lite responder terminating into NUM_REGS read/write
//             registers with per-register write strobes.
//             Define AXIL_REG_SLAVE_WSTRB_EN to honour byte-lane write strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    axil_reg_slave_if.slave                s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_stb
);
    localparam int                    c_BYTES       = DATA_WIDTH / 8;
    localparam int                    c_LSB         = $clog2(c_BYTES);
    localparam int                    c_IDXW        = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LIMIT  = ADDR_WIDTH'(NUM_REGS * c_BYTES);
    localparam logic [1:0]            c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]            c_RESP_SLVERR = 2'b10;

    logic                  r_aw_held;
    logic                  r_aw_oor;
    logic [c_IDXW-1:0]     r_aw_idx;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REGS-1:0]   r_wr_stb;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_commit;
    logic                  w_aw_held_nxt;
    logic                  w_w_held_nxt;
    logic                  w_bvalid_nxt;
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic [c_BYTES-1:0]    w_byte_en;
    logic                  w_ar_hs;
    logic                  w_ar_oor;
    logic [c_IDXW-1:0]     w_ar_idx;
    logic                  w_rvalid_nxt;

    assign w_aw_hs  = s_axi.awvalid & r_awready;
    assign w_w_hs   = s_axi.wvalid & r_wready;
    assign w_b_hs   = r_bvalid & s_axi.bready;
    // Held AW/W stay latched through the response so commit fires exactly once.
    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

    assign w_aw_held_nxt = r_aw_held ? ~w_b_hs : w_aw_hs;
    assign w_w_held_nxt  = r_w_held  ? ~w_b_hs : w_w_hs;
    assign w_bvalid_nxt  = r_bvalid  ? ~s_axi.bready : w_commit;
    assign w_wr_sel      = (w_commit & ~r_aw_oor) ? (NUM_REGS'(1) << r_aw_idx) : '0;

    assign w_ar_hs      = s_axi.arvalid & r_arready;
    assign w_ar_idx     = s_axi.araddr[c_LSB +: c_IDXW];
    assign w_ar_oor     = (s_axi.araddr >= c_ADDR_LIMIT);
    assign w_rvalid_nxt = r_rvalid ? ~s_axi.rready : w_ar_hs;

`ifdef AXIL_REG_SLAVE_WSTRB_EN
    logic [c_BYTES-1:0] r_w_strb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_strb <= '0;
        end else if (w_w_hs) begin
            r_w_strb <= s_axi.wstrb;
        end
    end

    assign w_byte_en = r_w_strb;
`else
    logic w_unused_wstrb;

    assign w_unused_wstrb = ^s_axi.wstrb;
    assign w_byte_en      = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_aw_oor  <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_wr_stb  <= '0;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            // Readies look at next-state so they drop on the accepting edge.
            r_awready <= ~w_aw_held_nxt & ~w_bvalid_nxt;
            r_wready  <= ~w_w_held_nxt & ~w_bvalid_nxt;
            r_wr_stb  <= w_wr_sel;
            if (w_aw_hs) begin
                r_aw_idx <= s_axi.awaddr[c_LSB +: c_IDXW];
                r_aw_oor <= (s_axi.awaddr >= c_ADDR_LIMIT);
            end
            if (w_w_hs) begin
                r_w_data <= s_axi.wdata;
            end
            if (w_commit) begin
                r_bresp <= r_aw_oor ? c_RESP_SLVERR : c_RESP_OKAY;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_regs[gi] <= '0;
            end else if (w_wr_sel[gi]) begin
                for (int b = 0; b < c_BYTES; b++) begin
                    if (w_byte_en[b]) begin
                        r_regs[gi][b*8 +: 8] <= r_w_data[b*8 +: 8];
                    end
                end
            end
        end

        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= ~w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_ar_oor ? '0 : r_regs[w_ar_idx];
                r_rresp <= w_ar_oor ? c_RESP_SLVERR : c_RESP_OKAY;
            end
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;
    assign reg_wr_stb    = r_wr_stb;

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
// ============================================================================
//  Module   : tb_axil_reg_slave
//  Brief    : Directed scoreboard bench for axil_reg_slave (16 x 32-bit regs).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_reg_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     reg_wr_stb;

    axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi      (bus),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [1:0]  exp_b_q [$];
    rsp_t        exp_r_q [$];
    logic [31:0] model [NR];
    int          stb_pulses = 0;
    logic [NR-1:0] stb_seen = '0;
    int          b_lat = 0;
    time         last_aw_t = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    // Response monitor: pops expectations whenever a B or R handshake is about to occur.
    always @(negedge clk) begin
        if (!rst) begin
            stb_seen   |= reg_wr_stb;
            stb_pulses += $countones(reg_wr_stb);
            if (bus.bvalid && bus.bready) begin
                if (exp_b_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b_unexpected: got bresp %0b expected no response", bus.bresp);
                end else begin
                    check("bresp", bus.bresp, exp_b_q.pop_front());
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL r_unexpected: got rdata %0h expected no response", bus.rdata);
                end else begin
                    check("rdata_rresp", {bus.rdata, bus.rresp}, exp_r_q.pop_front());
                end
            end
        end
    end

    task automatic wait_b();
        bit done = 0;
        int t = 0;
        b_lat = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
            if (bus.bvalid && b_lat == 0) b_lat = t;
            done = bus.bvalid && bus.bready;
            @(posedge clk); #1;
        end
        if (!done) timeout_fail("b_handshake");
    endtask

    task automatic wait_r();
        bit done = 0;
        int t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            done = bus.rvalid && bus.rready;
            @(posedge clk); #1;
            t++;
        end
        if (!done) timeout_fail("r_handshake");
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] resp, input int aw_delay, input bit wait_resp);
        bit aw_pend = 1, w_pend = 1, aw_hs, w_hs;
        int t = 0;
        exp_b_q.push_back(resp);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        if (aw_delay == 0) bus.awvalid = 1'b1;
        while ((aw_pend || w_pend) && t < 40) begin
            @(negedge clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            t++;
            if (aw_hs) begin bus.awvalid = 1'b0; aw_pend = 0; last_aw_t = $time - 1; end
            if (w_hs)  begin bus.wvalid = 1'b0; w_pend = 0; end
            if (w_hs && aw_pend) check("wready_after_w", bus.wready, 1'b0);
            if (aw_pend && t >= aw_delay) bus.awvalid = 1'b1;
        end
        if (aw_pend || w_pend) begin
            timeout_fail("aw_w_handshake");
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
        if (wait_resp) wait_b();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                           input bit wait_resp);
        rsp_t e;
        bit pend = 1, hs;
        int t = 0;
        e.data = data;
        e.resp = resp;
        exp_r_q.push_back(e);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (pend && t < 40) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            t++;
            if (hs) begin bus.arvalid = 1'b0; pend = 0; end
        end
        if (pend) begin
            timeout_fail("ar_handshake");
            bus.arvalid = 1'b0;
        end
        if (wait_resp) wait_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        time t0;
        logic [31:0] exp_strb;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 1;  bus.araddr = '0; bus.arvalid = 0; bus.rready = 1;
        for (int i = 0; i < NR; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready",  bus.wready,  1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_rvalid",  bus.rvalid,  1'b0);
        check("rst_bresp",   bus.bresp,   2'b00);
        check("rst_rresp",   bus.rresp,   2'b00);
        check("rst_rdata",   bus.rdata,   32'h0);
        check("rst_reg_q",   reg_q,       '0);
        check("rst_stb",     reg_wr_stb,  '0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", bus.awready, 1'b0);
        @(posedge clk); #1;
        check("awready_after_rst", bus.awready, 1'b1);
        check("wready_after_rst",  bus.wready,  1'b1);
        check("arready_after_rst", bus.arready, 1'b1);

        // Same-cycle AW+W to reg 1
        stb_seen = '0; stb_pulses = 0;
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 0, 1);
        model[1] = 32'hDEADBEEF;
        check("t1_b_latency", b_lat, 2);
        check("t1_stb_seen", stb_seen, 16'h0002);
        check("t1_stb_pulses", stb_pulses, 1);
        check("t1_reg_q", reg_q, model_vec());
        do_read(32'h04, 32'hDEADBEEF, 2'b00, 1);

        // W leads AW by three cycles, reg 15
        stb_seen = '0; stb_pulses = 0;
        do_write(32'h3C, 32'h0F0F1234, 4'hF, 2'b00, 3, 1);
        model[15] = 32'h0F0F1234;
        check("t2_b_latency", b_lat, 2);
        check("t2_stb_seen", stb_seen, 16'h8000);
        check("t2_reg_q", reg_q, model_vec());

        // Out of range write and read
        stb_seen = '0; stb_pulses = 0;
        do_write(32'h40, 32'h12345678, 4'hF, 2'b10, 0, 1);
        check("t3_stb_pulses", stb_pulses, 0);
        check("t3_reg_q", reg_q, model_vec());
        do_read(32'h40, 32'h0, 2'b10, 1);

        // Back-to-back writes: one every three cycles
        do_write(32'h08, 32'hA5A50001, 4'hF, 2'b00, 0, 1);
        t0 = last_aw_t;
        do_write(32'h0C, 32'hA5A50002, 4'hF, 2'b00, 0, 1);
        model[2] = 32'hA5A50001;
        model[3] = 32'hA5A50002;
        check("b2b_aw_spacing", last_aw_t - t0, 30);
        check("b2b_reg_q", reg_q, model_vec());

        // Stalled B channel with a second AW waiting
        bus.bready = 1'b0;
        do_write(32'h10, 32'h5555AAAA, 4'hF, 2'b00, 0, 0);
        model[4] = 32'h5555AAAA;
        @(posedge clk); #1;
        bus.awaddr  = 32'h14;
        bus.awvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_bvalid",  bus.bvalid,  1'b1);
            check("stall_bresp",   bus.bresp,   2'b00);
            check("stall_awready", bus.awready, 1'b0);
            check("stall_wready",  bus.wready,  1'b0);
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        wait_b();
        do_write(32'h14, 32'h12340014, 4'hF, 2'b00, 0, 1);
        model[5] = 32'h12340014;
        check("stall_reg_q", reg_q, model_vec());

        // Byte-lane strobes on reg 2
        do_write(32'h08, 32'h11223344, 4'hF, 2'b00, 0, 1);
        do_write(32'h08, 32'hAABBCCDD, 4'b0101, 2'b00, 0, 1);
`ifdef AXIL_REG_SLAVE_WSTRB_EN
        exp_strb = 32'h11BB33DD;
`else
        exp_strb = 32'hAABBCCDD;
`endif
        model[2] = exp_strb;
        check("wstrb_reg2", reg_q[2*DW +: DW], exp_strb);
        do_read(32'h08, exp_strb, 2'b00, 1);
        stb_seen = '0; stb_pulses = 0;
        do_write(32'h08, 32'hFFFFFFFF, 4'b0000, 2'b00, 0, 1);
`ifndef AXIL_REG_SLAVE_WSTRB_EN
        model[2] = 32'hFFFFFFFF;
`endif
        check("wstrb0_stb", stb_seen, 16'h0004);
        check("wstrb0_reg_q", reg_q, model_vec());

        // Reset with both responses pending
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        do_write(32'h18, 32'h00000066, 4'hF, 2'b00, 0, 0);
        do_read(32'h04, model[1], 2'b00, 0);
        @(posedge clk); #1;
        check("pre_rst_bvalid", bus.bvalid, 1'b1);
        check("pre_rst_rvalid", bus.rvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_bvalid", bus.bvalid, 1'b0);
        check("mid_rst_rvalid", bus.rvalid, 1'b0);
        check("mid_rst_reg_q", reg_q, '0);
        exp_b_q.delete();
        exp_r_q.delete();
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(posedge clk); #1;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_arready_before", bus.arready, 1'b0);
        @(posedge clk); #1;
        check("rel_awready", bus.awready, 1'b1);
        check("rel_wready",  bus.wready,  1'b1);
        check("rel_arready", bus.arready, 1'b1);
        do_read(32'h04, 32'h0, 2'b00, 1);

        repeat (2) @(posedge clk);
        check("b_queue_empty", exp_b_q.size(), 0);
        check("r_queue_empty", exp_r_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
